// File: rtl/output_serializer_pkg.sv
// Shared types and helpers for the output serializer: FSM state encoding
// and counter width sizing.
package output_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/output_serializer_if.sv
// Producer-to-serializer bus: valid/ready word handshake plus the serial
// line and its framing strobes.
interface output_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_input;
    logic                  data_valid;
    logic                  data_ready;
    logic                  serial_out;
    logic                  frame_active;
    logic                  bit_strobe;
    logic                  tx_done;

    modport master (
        output data_input, data_valid,
        input  data_ready, serial_out, frame_active, bit_strobe, tx_done
    );

    modport slave (
        input  data_input, data_valid,
        output data_ready, serial_out, frame_active, bit_strobe, tx_done
    );
endinterface

// File: rtl/serializer_bit_timer.sv
// Divider and bit counters for the serializer; flags the first cycle of
// each bit, the shift point, and the final cycle of the frame.
module serializer_bit_timer
    import output_serializer_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic enable,
    output logic bit_strobe,
    output logic shift_en,
    output logic last_cycle
);
    localparam int DIV_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W = cnt_width(DATA_WIDTH);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_WIDTH - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;

    // start takes priority so a reload in the last cycle of a frame
    // begins the next word from bit position zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (start) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (enable) begin
            if (div_cnt == DIV_MAX) begin
                div_cnt <= '0;
                bit_cnt <= (bit_cnt == BIT_MAX) ? '0 : bit_cnt + BIT_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    assign bit_strobe = enable && (div_cnt == '0);
    assign shift_en   = enable && (div_cnt == DIV_MAX);
    assign last_cycle = shift_en && (bit_cnt == BIT_MAX);

endmodule

// File: rtl/output_serializer.sv
// Parallel-to-serial output stage: one-word holding register in front of
// an MSB-first shifter, giving gap-free back-to-back frames.
module output_serializer
    import output_serializer_pkg::*;
#(
    parameter int   DATA_WIDTH   = 8,
    parameter int   CLKS_PER_BIT = 1,
    parameter logic IDLE_LEVEL   = 1'b0
) (
    input logic               clk,
    input logic               reset,
    output_serializer_if.slave bus
);
    state_t                state;
    logic [DATA_WIDTH-1:0] hold;
    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] shifter;
    logic                  serial_q;
    logic                  active_q;

    logic load;
    logic t_strobe;
    logic t_shift;
    logic t_last;

    // The hold word moves to the shifter when the line is free or the
    // current frame is in its final cycle.
    assign load = hold_valid && ((state == IDLE) || t_last);

    serializer_bit_timer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .start     (load),
        .enable    (state == SHIFT),
        .bit_strobe(t_strobe),
        .shift_en  (t_shift),
        .last_cycle(t_last)
    );

    // NOTE: every register here uses non-blocking assignment, so each
    // branch sees the pre-edge values of hold, shifter and state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            shifter    <= '0;
            serial_q   <= IDLE_LEVEL;
            active_q   <= 1'b0;
        end else begin
            // Transfer and load are exclusive: one needs hold empty,
            // the other needs it full.
            if (bus.data_valid && !hold_valid) begin
                hold       <= bus.data_input;
                hold_valid <= 1'b1;
            end else if (load) begin
                hold_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (hold_valid) begin
                        state    <= SHIFT;
                        shifter  <= hold;
                        serial_q <= hold[DATA_WIDTH-1];
                        active_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (t_last) begin
                        if (hold_valid) begin
                            shifter  <= hold;
                            serial_q <= hold[DATA_WIDTH-1];
                        end else begin
                            state    <= IDLE;
                            serial_q <= IDLE_LEVEL;
                            active_q <= 1'b0;
                        end
                    end else if (t_shift) begin
                        shifter  <= {shifter[DATA_WIDTH-2:0], 1'b0};
                        serial_q <= shifter[DATA_WIDTH-2];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_ready   = ~hold_valid;
    assign bus.serial_out   = serial_q;
    assign bus.frame_active = active_q;
    assign bus.bit_strobe   = t_strobe;
    assign bus.tx_done      = t_last;

endmodule

// File: tb/tb_output_serializer.sv
// Bench for output_serializer: two instances (1 and 4 clocks per bit)
// checked every cycle against a frame-schedule model, plus directed cases.
module tb_output_serializer;
    localparam int DW = 8;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    output_serializer_if #(.DATA_WIDTH(DW)) bus_a ();
    output_serializer_if #(.DATA_WIDTH(DW)) bus_b ();

    output_serializer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    output_serializer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(4), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    logic [1:0]         dv;
    logic [1:0][DW-1:0] din;
    logic [1:0]         so, fa, bs, td, rdy;

    assign bus_a.data_valid = dv[0];
    assign bus_a.data_input = din[0];
    assign bus_b.data_valid = dv[1];
    assign bus_b.data_input = din[1];
    assign so  = {bus_b.serial_out,   bus_a.serial_out};
    assign fa  = {bus_b.frame_active, bus_a.frame_active};
    assign bs  = {bus_b.bit_strobe,   bus_a.bit_strobe};
    assign td  = {bus_b.tx_done,      bus_a.tx_done};
    assign rdy = {bus_b.data_ready,   bus_a.data_ready};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cpb_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic idle_of(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: every accepted word becomes a scheduled frame [start, start+L-1].
    int               f_start [2][4];
    logic [DW-1:0]    f_word  [2][4];
    bit               f_live  [2][4];
    int               f_wp    [2];
    int               last_end[2];
    int               rdy_at  [2];
    bit [1:0]         acc;

    always @(negedge clk) begin : cmp
        logic  e_so, e_fa, e_bs, e_td, e_rdy;
        int    off, s, len, cpb;
        string tag;
        for (int i = 0; i < 2; i++) begin
            cpb = cpb_of(i);
            len = DW * cpb;
            tag = (i == 0) ? "a" : "b";
            e_so = idle_of(i);
            e_fa = 1'b0;
            e_bs = 1'b0;
            e_td = 1'b0;
            if (!reset) begin
                for (int k = 0; k < 4; k++) f_live[i][k] = 1'b0;
                f_wp[i]     = 0;
                rdy_at[i]   = 0;
                last_end[i] = -1;
                e_rdy       = 1'b1;
            end else begin
                e_rdy = (cyc >= rdy_at[i]);
                for (int k = 0; k < 4; k++) begin
                    if (f_live[i][k] && cyc >= f_start[i][k] && cyc < f_start[i][k] + len) begin
                        off  = cyc - f_start[i][k];
                        e_fa = 1'b1;
                        e_so = f_word[i][k][(DW - 1) - off / cpb];
                        e_bs = (off % cpb == 0);
                        e_td = (off == len - 1);
                    end
                end
            end
            check({tag, ".serial_out"},   32'(so[i]),  32'(e_so));
            check({tag, ".frame_active"}, 32'(fa[i]),  32'(e_fa));
            check({tag, ".bit_strobe"},   32'(bs[i]),  32'(e_bs));
            check({tag, ".tx_done"},      32'(td[i]),  32'(e_td));
            check({tag, ".data_ready"},   32'(rdy[i]), 32'(e_rdy));
            acc[i] = reset && dv[i] && e_rdy;
            if (acc[i]) begin
                s = (cyc + 2 > last_end[i] + 1) ? cyc + 2 : last_end[i] + 1;
                f_start[i][f_wp[i]] = s;
                f_word[i][f_wp[i]]  = din[i];
                f_live[i][f_wp[i]]  = 1'b1;
                f_wp[i]             = (f_wp[i] + 1) % 4;
                last_end[i]         = s + len - 1;
                rdy_at[i]           = s;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  got8, first8;
        logic [15:0] got16;
        int          sent, done_n, done_at, cnt, bs_n, first_bs;
        bit [1:0]    pend;

        reset = 1'b0;
        dv    = '0;
        din   = '0;
        pend  = '0;
        repeat (3) step();
        reset = 1'b1;

        // Reset/idle state held for 10 cycles.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle serial_out", 32'(so[0]), 32'd0);
            check("idle data_ready", 32'(rdy[0]), 32'd1);
            check("idle frame_active", 32'(fa[0]), 32'd0);
            step();
        end

        // Single word 0xA5, one clock per bit.
        dv[0] = 1'b1; din[0] = 8'hA5;
        got8 = '0; done_n = 0; done_at = -1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 9) got8 = {got8[6:0], so[0]};
            if (td[0]) begin done_n++; done_at = k; end
            if (k == 10) check("a5 idle after frame", 32'(so[0]), 32'd0);
            step();
            dv[0] = 1'b0;
        end
        check("a5 bits", 32'(got8), 32'h0000_00A5);
        check("a5 tx_done count", 32'(done_n), 32'd1);
        check("a5 tx_done cycle", 32'(done_at), 32'd9);

        // 0xFF then 0x00 with data_valid held high: 16 contiguous bits.
        dv[0] = 1'b1; din[0] = 8'hFF; sent = 0;
        got16 = '0; cnt = 0; done_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 17) begin
                got16 = {got16[14:0], so[0]};
                cnt  += int'(fa[0]);
            end
            if (k >= 3 && k <= 9) done_n += int'(!rdy[0]);
            if (k == 18) check("b2b frame_active drops", 32'(fa[0]), 32'd0);
            step();
            if (acc[0]) begin
                sent++;
                if (sent == 1) din[0] = 8'h00;
                else           dv[0]  = 1'b0;
            end
        end
        check("b2b bits", 32'(got16), 32'h0000_FF00);
        check("b2b frame_active cycles", 32'(cnt), 32'd16);
        check("b2b data_ready low while held", 32'(done_n), 32'd7);

        // 0x81 at four clocks per bit on the second instance.
        dv[1] = 1'b1; din[1] = 8'h81;
        got8 = '0; first8 = '0; bs_n = 0; first_bs = -1; done_n = 0; done_at = -1; cnt = 0;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            if (bs[1]) begin bs_n++; if (first_bs < 0) first_bs = k; end
            if (td[1]) begin done_n++; done_at = k; end
            cnt += int'(fa[1]);
            if (k >= 2 && k <= 33 && (k - 2) % 4 == 0) first8 = {first8[6:0], so[1]};
            if (k >= 2 && k <= 33 && (k - 2) % 4 == 3) got8 = {got8[6:0], so[1]};
            if (k == 35) check("cpb4 idle level", 32'(so[1]), 32'd1);
            step();
            dv[1] = 1'b0;
        end
        check("cpb4 bits first cycle", 32'(first8), 32'h0000_0081);
        check("cpb4 bits last cycle", 32'(got8), 32'h0000_0081);
        check("cpb4 bit_strobe count", 32'(bs_n), 32'd8);
        check("cpb4 first bit_strobe", 32'(first_bs), 32'd2);
        check("cpb4 tx_done count", 32'(done_n), 32'd1);
        check("cpb4 tx_done cycle", 32'(done_at), 32'd33);
        check("cpb4 frame length", 32'(cnt), 32'd32);

        // Reset after 3 bits of 0xC3 with 0x5A waiting in hold.
        dv[0] = 1'b1; din[0] = 8'hC3; sent = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            step();
            if (acc[0]) begin
                sent++;
                if (sent == 1) din[0] = 8'h5A;
                else           dv[0]  = 1'b0;
            end
        end
        check("midframe words accepted", 32'(sent), 32'd2);
        reset = 1'b0;
        #1;
        check("reset serial_out", 32'(so[0]), 32'd0);
        check("reset data_ready", 32'(rdy[0]), 32'd1);
        check("reset frame_active", 32'(fa[0]), 32'd0);
        @(negedge clk);
        step();
        reset = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cnt += int'(fa[0]) + int'(so[0]);
            step();
        end
        check("no bits after reset", 32'(cnt), 32'd0);

        // data_input wiggled while data_ready is low must not leak.
        dv[0] = 1'b1; din[0] = 8'h3C; sent = 0; got16 = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 17) got16 = {got16[14:0], so[0]};
            step();
            if (sent == 2) begin
                if (rdy[0]) dv[0] = 1'b0;
                else        din[0] = 8'($urandom);
            end else if (acc[0]) begin
                sent++;
                din[0] = (sent == 1) ? 8'h96 : 8'($urandom);
            end
        end
        dv[0] = 1'b0;
        check("held data bits", 32'(got16), 32'h0000_3C96);

        // Randomized traffic on both instances with occasional reset pulses.
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            step();
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 699) == 0) reset = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] || acc[i]) begin
                    pend[i] = ($urandom_range(0, 2) != 0);
                    dv[i]   = pend[i];
                    din[i]  = 8'($urandom);
                end
            end
        end
        dv = '0;
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
